// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: shared types and helpers for the sequential multiplier.
// Optional feature macro: SEQ_MULTIPLIER_SIGNED_EN (signed operation).
package seq_multiplier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Widest operand the magnitude helper handles; callers zero-extend into it.
   localparam int unsigned MAG_W = 64;

   typedef struct packed {
      logic             neg;
      logic [MAG_W-1:0] mag;
   } mag_sign_t;

   // Magnitude and sign of a w-bit two's-complement value held in the low
   // w bits of v. The most negative value maps to 2^(w-1), which still fits.
   function automatic mag_sign_t mag_sign(input logic [MAG_W-1:0] v,
                                          input int unsigned      w);
      mag_sign_t        r;
      logic [MAG_W-1:0] mask;
      mask  = ~({MAG_W{1'b1}} << w);
      r.neg = |(v & (MAG_W'(1) << (w - 1)));
      r.mag = r.neg ? ((~v + MAG_W'(1)) & mask) : (v & mask);
      return r;
   endfunction

endpackage

// File: rtl/seq_multiplier_datapath.sv
// seq_multiplier_datapath: shift-and-add registers (acc, mcand, mplier).
// Signedness (macro SEQ_MULTIPLIER_SIGNED_EN) is handled by the top level;
// this block only ever sees unsigned magnitudes.
module seq_multiplier_datapath #(
   parameter int unsigned N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           step,
   input  logic [N-1:0]   a_mag,
   input  logic [N-1:0]   b_mag,
   output logic [2*N-1:0] acc_next,
   output logic           done
);

   logic [2*N-1:0] acc;
   logic [2*N-1:0] mcand;
   logic [N-1:0]   mplier;

   // Accumulator value after the current step, and end-of-multiply detect.
   always_comb begin
      acc_next = mplier[0] ? (acc + mcand) : acc;
      done     = ((mplier >> 1) == '0);
   end

   // Operand load on handshake, one add/shift per step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{N{1'b0}}, a_mag};
         mplier <= b_mag;
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: handshaked sequential shift-and-add multiplier.
// Define SEQ_MULTIPLIER_SIGNED_EN to honour signed_i; otherwise all
// transactions are unsigned and signed_i is ignored.
module seq_multiplier #(
   parameter int unsigned N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           valid_i,
   output logic           ready_i,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           signed_i,
   output logic           valid_o,
   input  logic           ready_o,
   output logic [2*N-1:0] product
);
   import seq_multiplier_pkg::*;

   state_t         state;
   state_t         state_next;
   logic           accept;
   logic           load;
   logic           step;
   logic           dp_done;
   logic           zero_in;
   logic [N-1:0]   a_mag;
   logic [N-1:0]   b_mag;
   logic [2*N-1:0] acc_next;
   logic [2*N-1:0] result;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
   mag_sign_t a_ms;
   mag_sign_t b_ms;
   logic      neg_in;
   logic      neg;

   // Operand magnitudes and product sign for the incoming transaction.
   always_comb begin
      a_ms   = mag_sign(MAG_W'(a), N);
      b_ms   = mag_sign(MAG_W'(b), N);
      a_mag  = signed_i ? N'(a_ms.mag) : a;
      b_mag  = signed_i ? N'(b_ms.mag) : b;
      neg_in = signed_i & (a_ms.neg ^ b_ms.neg);
      result = neg ? ((2*N)'(0) - acc_next) : acc_next;
   end

   // Product sign captured at the input handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      neg <= 1'b0;
      else if (accept) neg <= neg_in;
   end
`else
   logic unused_signed;
   assign unused_signed = signed_i;

   // Unsigned only: operands pass straight through, no final negation.
   always_comb begin
      a_mag  = a;
      b_mag  = b;
      result = acc_next;
   end
`endif

   assign ready_i = (state == IDLE);
   assign accept  = valid_i & ready_i;
   assign zero_in = (a_mag == '0) | (b_mag == '0);

   seq_multiplier_datapath #(.N(N)) u_datapath (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .step     (step),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .acc_next (acc_next),
      .done     (dp_done)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and datapath control.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               load       = 1'b1;
               state_next = zero_in ? DONE : BUSY;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (dp_done) state_next = DONE;
         end
         DONE: begin
            if (valid_o && ready_o) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Product register and output valid. A zero operand enters DONE with
   // valid_o still low and raises it one cycle later, so its result appears
   // at the same edge as the fastest multiply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product <= '0;
         valid_o <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept && zero_in) product <= '0;
            end
            BUSY: begin
               if (dp_done) begin
                  product <= result;
                  valid_o <= 1'b1;
               end
            end
            DONE: begin
               if (!valid_o)     valid_o <= 1'b1;
               else if (ready_o) valid_o <= 1'b0;
            end
            default: valid_o <= 1'b0;
         endcase
      end
   end

endmodule
